// File: rtl/cart_ram_bridge.sv
// Byte-port responder for the cartridge ROM/RAM bus: turns byte reads/writes into
// 16-bit word request/ack transactions, with a one-word read cache in front.
module cart_ram_bridge #(
    parameter int ADDR_WIDTH = 25
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [7:0]            ram_din_i,
    input  logic                  ram_we_i,
    input  logic                  ram_rd_i,
    output logic [7:0]            ram_dout_o,
    output logic                  ram_ready_o,
    output logic [ADDR_WIDTH-2:0] mem_addr_o,
    output logic [15:0]           mem_wdata_o,
    output logic [1:0]            mem_be_o,
    output logic                  mem_req_o,
    output logic                  mem_wr_o,
    input  logic                  mem_ack_i,
    input  logic [15:0]           mem_rdata_i,
    input  logic                  mem_rvalid_i
);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

    state_t                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-2:0] tag_q, tag_d;
    logic [15:0]           data_q, data_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_din_q, wr_din_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [1:0]            mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-2:0] mem_addr_q, mem_addr_d;
    logic [15:0]           mem_wdata_q, mem_wdata_d;

    logic [ADDR_WIDTH-2:0] rd_word;
    logic                  miss;

    assign rd_word = ram_addr_i[ADDR_WIDTH-1:1];
    assign miss    = !valid_q || (tag_q != rd_word);

    // NOTE: every variable driven here gets its hold value first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        wr_pend_d   = wr_pend_q;
        wr_addr_d   = wr_addr_q;
        wr_din_d    = wr_din_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (wr_pend_q) begin
                    state_d     = WR_REQ;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = wr_addr_q[ADDR_WIDTH-1:1];
                    mem_be_d    = wr_addr_q[0] ? 2'b10 : 2'b01;
                    mem_wdata_d = {wr_din_q, wr_din_q};
                end else if (ram_rd_i && miss) begin
                    state_d    = RD_REQ;
                    mem_req_d  = 1'b1;
                    mem_wr_d   = 1'b0;
                    mem_be_d   = 2'b11;
                    mem_addr_d = rd_word;
                end
            end
            RD_REQ: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    if (mem_rvalid_i) begin
                        data_d  = mem_rdata_i;
                        tag_d   = mem_addr_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (mem_rvalid_i) begin
                    data_d  = mem_rdata_i;
                    tag_d   = mem_addr_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    wr_pend_d = 1'b0;
                    state_d   = IDLE;
                    // Write-through keeps the cached word coherent with the backend.
                    if (valid_q && (tag_q == mem_addr_q)) begin
                        if (mem_be_q[1]) data_d[15:8] = mem_wdata_q[15:8];
                        else             data_d[7:0]  = mem_wdata_q[7:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // NOTE: capture sits after the case so a ram_we in the ack cycle keeps wr_pend set.
        if (ram_we_i) begin
            wr_pend_d = 1'b1;
            wr_addr_d = ram_addr_i;
            wr_din_d  = ram_din_i;
        end
    end

    // NOTE: the cache data register is reset too, so ram_dout reads 8'hFF out of reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            tag_q       <= '0;
            data_q      <= 16'hFFFF;
            wr_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_din_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_be_q    <= 2'b11;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            wr_pend_q   <= wr_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_din_q    <= wr_din_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ram_dout_o  = ram_addr_i[0] ? data_q[15:8] : data_q[7:0];
    assign ram_ready_o = (state_q == IDLE) && !wr_pend_q && !(ram_rd_i && miss);
    assign mem_req_o   = mem_req_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
